prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a byte stream (count, little-endian words, XOR checksum),
// writes the words into instruction memory and holds the CPU until the image
// has been loaded and verified.
module prog_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    cnt_lo;
  logic [7:0]    chk;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] last_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   asm_word;
  logic [15:0]   n_words;
  logic          n_ok;
  logic          accept;

  assign accept     = byte_valid & byte_ready;
  assign n_words    = {byte_data, cnt_lo};
  assign n_ok       = (n_words != 16'd0) && ({16'd0, n_words} <= 32'(MAX_WORDS));
  assign imem_addr  = word_idx;
  assign imem_wdata = asm_word;

  // State register; reset wins over any byte presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= S_CNT_LO;
    else     state <= state_nx;
  end

  // Next-state and Moore outputs. byte_valid is used directly (byte_ready is
  // 1 in every state that consumes bytes) so no loop through byte_ready forms.
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_CNT_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = S_CNT_HI;
      end
      S_CNT_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = n_ok ? S_DATA : S_ERR;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        imem_we  = 1'b1;
        state_nx = (word_idx == last_idx) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = (byte_data == chk) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_nx = S_CNT_LO;
    endcase
  end

  // Datapath: count capture, word assembly, running checksum, word index.
  // The index stops at the last word so it never addresses beyond N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo   <= '0;
      last_idx <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      chk      <= '0;
      asm_word <= '0;
    end else begin
      case (state)
        S_CNT_LO: if (accept) cnt_lo <= byte_data;
        S_CNT_HI: if (accept) last_idx <= AW'(n_words - 16'd1);
        S_DATA: begin
          if (accept) begin
            asm_word[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            chk      <= chk ^ byte_data;
          end
        end
        S_WRITE: if (word_idx != last_idx) word_idx <= word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them whenever imem_we is seen.
module tb_prog_loader;

  localparam int MAX_WORDS = 1024;
  localparam int AW        = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] exp_q[$];
  logic [31:0] img [0:MAX_WORDS-1];

  prog_loader #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), {16'd0, e[47:32]});
        check("write_data", imem_wdata, e[31:0]);
      end
      check("ready_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic do_reset(input logic junk_valid);
    @(posedge clk); #1;
    rst = 1'b1;
    byte_valid = junk_valid;
    byte_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    byte_data = 8'hEE;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one byte and hold it until an edge accepts it (bounded).
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic rdy;
    bit acc;
    acc = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      acc = rdy;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", b);
    end
    if (gaps) idle(1 + int'($urandom_range(0, 3)));
  endtask

  task automatic send_image(input int n, input bit chk_bad, input logic [7:0] chk_val, input bit gaps);
    logic [7:0] c;
    logic [31:0] w;
    c = 8'h00;
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int k = 0; k < n; k++) begin
      w = img[k];
      exp_q.push_back({k[15:0], w});
      for (int j = 0; j < 4; j++) begin
        c = c ^ w[8*j +: 8];
        send_byte(w[8*j +: 8], (j == 3) ? 1'b0 : gaps);
      end
      check("we_latency", 32'(imem_we), 32'd1);
      if (gaps) idle(1 + int'($urandom_range(0, 3)));
    end
    send_byte(chk_bad ? chk_val : c, gaps);
  endtask

  task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
    for (int i = 0; i < 40 && !(done || error); i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({name, "_ready"}, 32'(byte_ready), 32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    do_reset(1'b1);
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // One-word image, checksum B6.
    img[0] = 32'h00A00513;
    send_image(1, 1'b0, 8'h00, 1'b0);
    wait_end("one_word", 1'b1, 1'b0);

    // Zero count rejected.
    do_reset(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end("zero_count", 1'b0, 1'b1);

    // Count one over capacity rejected.
    do_reset(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_end("over_count", 1'b0, 1'b1);

    // Two words with a wrong checksum (true value 91).
    do_reset(1'b0);
    img[0] = 32'h00000093;
    img[1] = 32'h00100113;
    send_image(2, 1'b1, 8'h00, 1'b0);
    wait_end("bad_chk", 1'b0, 1'b1);

    // Same image, correct checksum, with idle gaps between bytes.
    do_reset(1'b0);
    send_image(2, 1'b0, 8'h00, 1'b1);
    wait_end("gaps", 1'b1, 1'b0);

    // Abort after three data bytes, then a fresh one-word image.
    do_reset(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    do_reset(1'b1);
    check("abort_ready", 32'(byte_ready), 32'd1);
    img[0] = 32'h00100073;
    send_image(1, 1'b0, 8'h00, 1'b0);
    wait_end("abort_reload", 1'b1, 1'b0);

    // Full-capacity image, word k = k.
    do_reset(1'b0);
    for (int k = 0; k < MAX_WORDS; k++) img[k] = k;
    send_image(MAX_WORDS, 1'b0, 8'h00, 1'b0);
    wait_end("full", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
